// File: rtl/csr_rmw_sequencer.sv
// CSR read-modify-write sequencer: serialises pipeline CSR instructions and
// trap-unit plain writes through a shared CSR file read port, ALU and write port.
module csr_rmw_sequencer #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_src,
    input  logic              req_wskip,
    input  logic              trap_valid,
    output logic              trap_ready,
    input  logic [ADDR_W-1:0] trap_addr,
    input  logic [DATA_W-1:0] trap_wdata,
    output logic              csr_re,
    output logic [ADDR_W-1:0] csr_raddr,
    input  logic [DATA_W-1:0] csr_rdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_res,
    output logic              csr_we,
    output logic [ADDR_W-1:0] csr_waddr,
    output logic [DATA_W-1:0] csr_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_src,
    output logic              resp_err,
    output logic              busy
);

    localparam logic [1:0] OP_RW  = 2'd0;
    localparam logic [1:0] OP_RS  = 2'd1;
    localparam logic [1:0] OP_RC  = 2'd2;
    localparam logic [1:0] OP_ILL = 2'd3;

    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_OR     = 2'd1;
    localparam logic [1:0] ALU_ANDNOT = 2'd2;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_trap_acc;
    logic               w_req_acc;
    logic               w_we;

    logic [ADDR_W-1:0]  r_addr;
    logic [1:0]         r_op;
    logic [DATA_W-1:0]  r_src;
    logic               r_wskip;
    logic               r_from_trap;
    logic [DATA_W-1:0]  r_old;
    logic [DATA_W-1:0]  r_res;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Trap requests have strict priority over the pipeline in IDLE.
    always_comb begin
        w_next     = r_state;
        w_trap_acc = 1'b0;
        w_req_acc  = 1'b0;
        case (r_state)
            IDLE: begin
                w_trap_acc = trap_valid;
                w_req_acc  = req_valid & ~trap_valid;
                if (trap_valid || req_valid) begin
                    w_next = READ;
                end
            end
            READ:    w_next = EXEC;
            EXEC:    w_next = WRITE;
            WRITE:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr      <= '0;
            r_op        <= '0;
            r_src       <= '0;
            r_wskip     <= 1'b0;
            r_from_trap <= 1'b0;
            r_old       <= '0;
            r_res       <= '0;
        end else begin
            if (w_trap_acc) begin
                r_addr      <= trap_addr;
                r_op        <= OP_RW;
                r_src       <= trap_wdata;
                r_wskip     <= 1'b0;
                r_from_trap <= 1'b1;
            end else if (w_req_acc) begin
                r_addr      <= req_addr;
                r_op        <= req_op;
                r_src       <= req_src;
                r_wskip     <= req_wskip;
                r_from_trap <= 1'b0;
            end
            if (r_state == EXEC) begin
                r_old <= csr_rdata;
                r_res <= alu_res;
            end
        end
    end

    assign w_we = (r_state == WRITE) & ~r_wskip & (r_op != OP_ILL);

    always_comb begin
        trap_ready = (r_state == IDLE);
        req_ready  = (r_state == IDLE) & ~trap_valid;
        busy       = (r_state != IDLE);
        csr_re     = 1'b0;
        csr_raddr  = '0;
        alu_a      = '0;
        alu_b      = '0;
        alu_op     = ALU_ADD;
        csr_we     = w_we;
        csr_waddr  = '0;
        csr_wdata  = '0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_src   = 1'b0;
        resp_err   = 1'b0;
        if (r_state == READ) begin
            csr_re    = 1'b1;
            csr_raddr = r_addr;
        end
        // RW replaces the value: ADD with zero passes the operand through.
        if (r_state == EXEC) begin
            alu_b = r_src;
            case (r_op)
                OP_RS:   begin alu_op = ALU_OR;     alu_a = csr_rdata; end
                OP_RC:   begin alu_op = ALU_ANDNOT; alu_a = csr_rdata; end
                OP_RW:   begin alu_op = ALU_ADD;    alu_a = '0;        end
                default: begin alu_op = ALU_ADD;    alu_a = csr_rdata; end
            endcase
        end
        if (w_we) begin
            csr_waddr = r_addr;
            csr_wdata = r_res;
        end
        if (r_state == WRITE) begin
            resp_valid = 1'b1;
            resp_rdata = r_old;
            resp_src   = r_from_trap;
            resp_err   = (r_op == OP_ILL);
        end
    end

endmodule

// File: tb/tb_csr_rmw_sequencer.sv
// Directed bench for csr_rmw_sequencer: CSR file and ALU environment, a
// transaction-level model checked every cycle, and literal result checks.
module tb_csr_rmw_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [11:0] req_addr = '0;
    logic [1:0]  req_op = '0;
    logic [63:0] req_src = '0;
    logic        req_wskip = 1'b0;
    logic        trap_valid = 1'b0;
    logic        trap_ready;
    logic [11:0] trap_addr = '0;
    logic [63:0] trap_wdata = '0;
    logic        csr_re;
    logic [11:0] csr_raddr;
    logic [63:0] csr_rdata = '0;
    logic [63:0] alu_a, alu_b, alu_res;
    logic [1:0]  alu_op;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [63:0] csr_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_src;
    logic        resp_err;
    logic        busy;

    csr_rmw_sequencer #(.DATA_W(64), .ADDR_W(12)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_op(req_op), .req_src(req_src), .req_wskip(req_wskip),
        .trap_valid(trap_valid), .trap_ready(trap_ready), .trap_addr(trap_addr),
        .trap_wdata(trap_wdata),
        .csr_re(csr_re), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_src(resp_src),
        .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Environment: ALU and CSR file with one-cycle read latency.
    assign alu_res = (alu_op == 2'd0) ? alu_a + alu_b :
                     (alu_op == 2'd1) ? (alu_a | alu_b) :
                     (alu_op == 2'd2) ? (alu_a & ~alu_b) : 64'd0;

    logic [63:0] env [0:4095];
    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [63:0] pre_val = '0;

    always @(posedge clk) begin
        cyc++;
        if (pre_we) env[pre_addr] <= pre_val;
        if (csr_re) csr_rdata <= env[csr_raddr];
        if (csr_we) env[csr_waddr] <= csr_wdata;
    end

    // Transaction model: one operation in flight, WRITE three edges after acceptance.
    logic [63:0] mmem [0:4095];
    int          phase = 0;
    logic [11:0] m_addr;
    logic [1:0]  m_op;
    logic [63:0] m_src, m_old, m_new;
    logic        m_trap, m_we;

    task automatic m_load(input logic [11:0] a, input logic [1:0] op, input logic [63:0] s,
                          input logic ws, input logic tr);
        m_addr = a; m_op = op; m_src = s; m_trap = tr;
        m_old  = mmem[a];
        m_new  = (op == 2'd0) ? s : (op == 2'd1) ? (m_old | s) : (m_old & ~s);
        m_we   = (op != 2'd3) && !ws;
        phase  = 1;
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase = 0;
        end else begin
            if (pre_we) mmem[pre_addr] = pre_val;
            if (phase == 0) begin
                if (trap_valid) m_load(trap_addr, 2'd0, trap_wdata, 1'b0, 1'b1);
                else if (req_valid) m_load(req_addr, req_op, req_src, req_wskip, 1'b0);
            end else if (phase == 3) begin
                if (m_we) mmem[m_addr] = m_new;
                phase = 0;
            end else begin
                phase++;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, phase != 0);
        chk("trap_ready", trap_ready, phase == 0);
        chk("req_ready", req_ready, (phase == 0) && !trap_valid);
        chk("csr_re", csr_re, phase == 1);
        chk("csr_raddr", csr_raddr, (phase == 1) ? m_addr : 12'd0);
        chk("csr_we", csr_we, (phase == 3) && m_we);
        chk("csr_waddr", csr_waddr, ((phase == 3) && m_we) ? m_addr : 12'd0);
        chk("csr_wdata", csr_wdata, ((phase == 3) && m_we) ? m_new : 64'd0);
        chk("resp_valid", resp_valid, phase == 3);
        chk("resp_rdata", resp_rdata, (phase == 3) ? m_old : 64'd0);
        chk("resp_src", resp_src, (phase == 3) && m_trap);
        chk("resp_err", resp_err, (phase == 3) && (m_op == 2'd3));
        if (phase == 2) begin
            if (m_op != 2'd3) begin
                chk("alu_op", alu_op, m_op);
                chk("alu_a", alu_a, (m_op == 2'd0) ? 64'd0 : m_old);
                chk("alu_b", alu_b, m_src);
            end
        end else begin
            chk("alu_op_idle", alu_op, 2'd0);
            chk("alu_a_idle", alu_a, 64'd0);
            chk("alu_b_idle", alu_b, 64'd0);
        end
    end

    // Record every response and write the DUT issues.
    int          n_resp = 0, n_we = 0;
    logic [63:0] rec_rdata [0:31];
    logic        rec_src [0:31];
    logic        rec_err [0:31];
    int          rec_cyc [0:31];
    logic [11:0] rec_waddr [0:31];
    logic [63:0] rec_wdata [0:31];

    always @(negedge clk) begin
        if (resp_valid && n_resp < 32) begin
            rec_rdata[n_resp] = resp_rdata;
            rec_src[n_resp]   = resp_src;
            rec_err[n_resp]   = resp_err;
            rec_cyc[n_resp]   = cyc;
            n_resp++;
        end
        if (csr_we && n_we < 32) begin
            rec_waddr[n_we] = csr_waddr;
            rec_wdata[n_we] = csr_wdata;
            n_we++;
        end
    end

    task automatic preset(input logic [11:0] a, input logic [63:0] v);
        @(negedge clk);
        pre_addr = a; pre_val = v; pre_we = 1'b1;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic send_req(input logic [1:0] op, input logic [11:0] a, input logic [63:0] s,
                            input logic ws);
        int n;
        n = 0;
        req_op = op; req_addr = a; req_src = s; req_wskip = ws; req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept", req_ready, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic send_trap(input logic [11:0] a, input logic [63:0] d);
        int n;
        n = 0;
        trap_addr = a; trap_wdata = d; trap_valid = 1'b1;
        @(negedge clk);
        while (!trap_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("trap_accept", trap_ready, 1'b1);
        @(posedge clk);
        #1 trap_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    int rel_cyc;

    initial begin
        #1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_trap_ready", trap_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // CSRRS 0x300: 0x1 | 0x8
        preset(12'h300, 64'h1);
        send_req(2'd1, 12'h300, 64'h8, 1'b0);
        settle();
        chk("rs_wdata", rec_wdata[0], 64'h9);
        chk("rs_waddr", rec_waddr[0], 12'h300);
        chk("rs_rdata", rec_rdata[0], 64'h1);
        chk("rs_err", rec_err[0], 1'b0);

        // CSRRC 0x304: 0xFF & ~0xF0, then the same with the write skipped
        preset(12'h304, 64'hFF);
        send_req(2'd2, 12'h304, 64'hF0, 1'b0);
        settle();
        chk("rc_wdata", rec_wdata[1], 64'h0F);
        chk("rc_rdata", rec_rdata[1], 64'hFF);
        preset(12'h304, 64'hFF);
        send_req(2'd2, 12'h304, 64'hF0, 1'b1);
        settle();
        chk("rc_skip_rdata", rec_rdata[2], 64'hFF);
        chk("rc_skip_nwrites", n_we, 2);
        chk("rc_skip_env", env[12'h304], 64'hFF);

        // CSRRW 0x341
        preset(12'h341, 64'h1234);
        send_req(2'd0, 12'h341, 64'hDEAD, 1'b0);
        settle();
        chk("rw_wdata", rec_wdata[2], 64'hDEAD);
        chk("rw_waddr", rec_waddr[2], 12'h341);
        chk("rw_rdata", rec_rdata[3], 64'h1234);

        // Trap and pipeline request presented together
        preset(12'h342, 64'h5);
        fork
            send_trap(12'h342, 64'h8000_0000);
            send_req(2'd1, 12'h300, 64'h2, 1'b0);
        join
        settle();
        chk("trap_src", rec_src[4], 1'b1);
        chk("trap_rdata", rec_rdata[4], 64'h5);
        chk("trap_waddr", rec_waddr[3], 12'h342);
        chk("trap_wdata", rec_wdata[3], 64'h8000_0000);
        chk("pipe_src", rec_src[5], 1'b0);
        chk("pipe_rdata", rec_rdata[5], 64'h9);
        chk("pipe_wdata", rec_wdata[4], 64'hB);
        chk("pipe_gap", rec_cyc[5] - rec_cyc[4], 4);
        chk("model_300", mmem[12'h300], 64'hB);

        // Illegal op: read happens, no write, error flagged
        preset(12'h305, 64'h77);
        send_req(2'd3, 12'h305, 64'h1, 1'b0);
        settle();
        chk("ill_err", rec_err[6], 1'b1);
        chk("ill_rdata", rec_rdata[6], 64'h77);
        chk("ill_nwrites", n_we, 5);

        // Reset pulsed during EXEC aborts the operation
        preset(12'h306, 64'h11);
        preset(12'h307, 64'h3);
        send_req(2'd1, 12'h306, 64'h100, 1'b0);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_we", csr_we, 1'b0);
        chk("abort_resp", resp_valid, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_nresp", n_resp, 7);
        chk("abort_nwrites", n_we, 5);
        chk("abort_env", env[12'h306], 64'h11);

        // Request waiting through reset is taken at the first edge after release
        req_op = 2'd0; req_addr = 12'h307; req_src = 64'hABC; req_wskip = 1'b0;
        req_valid = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        rel_cyc = cyc;
        @(posedge clk);
        #1 req_valid = 1'b0;
        settle();
        chk("post_rst_rdata", rec_rdata[7], 64'h3);
        chk("post_rst_wdata", rec_wdata[5], 64'hABC);
        chk("post_rst_waddr", rec_waddr[5], 12'h307);
        chk("post_rst_latency", rec_cyc[7] - rel_cyc, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

endmodule
